uart_pkt_ctrl: RTL and testbench
================================

# uart_pkt_ctrl

Packet-level controller behind the 16x-oversampling UART receiver. Consumes the receiver's byte strobe, data and frame-error flag, parses framed command packets, and sequences byte writes into the photo-frame pixel buffer. Also owns the buffer write pointer and the display-update trigger. Reports per-packet success or failure to the status logic.

## Interface
- `ADDR_W`, 16: pixel buffer address width.
- `TIMEOUT`, 50000: idle clock cycles allowed between bytes inside a packet.
- `SYNC`, 8'hA5: packet start byte.

Ports:
- `clock`  in  1  system clock, same domain as the UART receiver.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid when `rx_valid` is high.
- `rx_valid`  in  1  single-cycle byte strobe from the receiver.
- `rx_frame_err`  in  1  stop-bit error flag, sampled with `rx_valid`.
- `mem_we`  out  1  buffer write strobe, one cycle per payload byte.
- `mem_addr`  out  ADDR_W  buffer write address.
- `mem_wdata`  out  8  buffer write data.
- `show_pulse`  out  1  one-cycle display-update request.
- `pkt_done`  out  1  one-cycle pulse: packet accepted.
- `pkt_err`  out  1  one-cycle pulse: packet rejected or aborted.
- `err_code`  out  2  valid with `pkt_err`:
  - 0 = bad command or length
  - 1 = checksum mismatch
  - 2 = frame error
  - 3 = timeout
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- Packet format: SYNC, CMD, LEN_H, LEN_L, LEN payload bytes, CSUM.
  - LEN is 16-bit, unsigned, big-endian.
  - CSUM = (CMD + LEN_H + LEN_L + all payload bytes) mod 256. SYNC is excluded.
- States: IDLE, CMD, LEN_H, LEN_L, PAYLOAD, CSUM. Each transition is taken on `rx_valid` only.
  - IDLE: byte == SYNC → CMD; any other byte is ignored.
  - CMD → LEN_H → LEN_L.
  - LEN_L: LEN == 0 → CSUM; otherwise → PAYLOAD, with the remaining-byte counter loaded with LEN.
  - PAYLOAD: decrement the counter on each byte; on the last byte → CSUM.
  - CSUM: compare the byte with the running sum, then → IDLE with exactly one of `pkt_done` / `pkt_err`.
- Commands:
  - 0x01 WRITE: each payload byte is written to `wr_ptr`, then `wr_ptr` increments and wraps modulo 2^ADDR_W. Writes are committed as they arrive; a later checksum failure does not undo them.
  - 0x02 SET_ADDR: LEN must be 2. Payload is the address, big-endian, truncated to ADDR_W. It loads `wr_ptr` only on a good checksum.
  - 0x03 SHOW: LEN must be 0. A good checksum asserts `show_pulse` together with `pkt_done`.
  - Any other CMD, or a wrong LEN for SET_ADDR/SHOW: the payload is consumed with no writes. At CSUM, `pkt_err` fires with code 0. This takes precedence over checksum mismatch.
- Frame error:
  - `rx_valid` with `rx_frame_err` = 1 in a non-IDLE state: discard the byte, go to IDLE, `pkt_err` code 2.
  - In IDLE: the byte is ignored silently.
- Timeout:
  - The counter clears on every `rx_valid` and counts while not IDLE.
  - After TIMEOUT consecutive cycles without `rx_valid`: go to IDLE, `pkt_err` code 3.
- Reset: state IDLE, `wr_ptr` = 0. All outputs are 0, including `mem_addr`, `mem_wdata` and `err_code`.

## Timing
- All outputs are registered.
- `mem_we`, `mem_addr`, `mem_wdata` are valid the cycle after the payload `rx_valid`.
- `mem_addr` and `mem_wdata` hold their last values when `mem_we` is low.
- `pkt_done`, `pkt_err`, `show_pulse` assert the cycle after the CSUM `rx_valid`, or the cycle after the timeout/frame-error event.
- `busy` rises the cycle after SYNC is accepted and falls together with the completion pulse.
- Only one pulse is ever produced per packet.
- `rx_valid` in the same cycle as timeout expiry: the byte wins; the counter clears and there is no timeout.
- A SYNC byte arriving mid-packet is treated as ordinary data.
- Back-to-back packets: SYNC may arrive on the cycle immediately after CSUM.
- Reset mid-packet: immediate return to IDLE; no completion pulse is emitted.
- Bytes arrive at least 16 clocks apart, so no input buffering is required.

## Test plan
- SET_ADDR: A5 02 00 02 01 00 05 → `pkt_done`; `wr_ptr` = 0x0100; no `mem_we`.
- WRITE after SET_ADDR: A5 01 00 03 11 22 33 6A → three `mem_we` pulses at 0x0100/0x0101/0x0102 with data 11/22/33; then `pkt_done`.
- SHOW good and bad:
  - A5 03 00 00 03 → `show_pulse` + `pkt_done`.
  - A5 03 00 00 04 → `pkt_err` code 1; no `show_pulse`.
- Timeout: A5 01 then silence → `pkt_err` code 3 exactly TIMEOUT cycles after the last byte; then A5 03 00 00 03 is accepted normally.
- Frame error: A5 01 00 02 11, then a byte with `rx_frame_err` = 1 → `pkt_err` code 2; only one write (0x11) has occurred.
- Wrap and bad length:
  - `wr_ptr` = 0xFFFF, WRITE 2 bytes → addresses 0xFFFF then 0x0000.
  - A5 02 00 01 07 0A → `pkt_err` code 0; `wr_ptr` unchanged.

Source files
------------

// File: rtl/uart_pkt_ctrl_if.sv
// Bundle of the receiver-facing byte stream and the controller's buffer,
// display and status outputs. The receiver side drives the master modport,
// the packet controller uses the slave modport.
interface uart_pkt_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_frame_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              show_pulse;
  logic              pkt_done;
  logic              pkt_err;
  logic [1:0]        err_code;
  logic              busy;

  modport master (
    output rx_data, rx_valid, rx_frame_err,
    input  mem_we, mem_addr, mem_wdata, show_pulse, pkt_done, pkt_err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_valid, rx_frame_err,
    output mem_we, mem_addr, mem_wdata, show_pulse, pkt_done, pkt_err, err_code, busy
  );
endinterface

// File: rtl/uart_pkt_ctrl.sv
// Packet-level controller behind the UART receiver: parses
// SYNC/CMD/LEN_H/LEN_L/payload/CSUM packets, writes payload bytes into the
// pixel buffer, owns the buffer write pointer and the display trigger, and
// reports one done/error pulse per packet. All outputs are registered.
module uart_pkt_ctrl #(
  parameter int         ADDR_W  = 16,
  parameter int         TIMEOUT = 50000,
  parameter logic [7:0] SYNC    = 8'hA5
) (
  input logic           clock,
  input logic           reset_n,
  uart_pkt_ctrl_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] CMD_WRITE    = 8'h01;
  localparam logic [7:0] CMD_SET_ADDR = 8'h02;
  localparam logic [7:0] CMD_SHOW     = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN_H   = 3'd2,
    S_LEN_L   = 3'd3,
    S_PAYLOAD = 3'd4,
    S_CSUM    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        len_h_q, len_h_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic [15:0]       addr_q, addr_d;
  logic              bad_q, bad_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              show_q, show_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              busy_q;
  logic [15:0]       len_s;

  // A command is rejected if unknown or if its length does not fit it.
  function automatic logic cmd_bad(input logic [7:0] cmd, input logic [15:0] len);
    logic bad;
    case (cmd)
      CMD_WRITE:    bad = 1'b0;
      CMD_SET_ADDR: bad = (len != 16'd2);
      CMD_SHOW:     bad = (len != 16'd0);
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign len_s = {len_h_q, bus.rx_data};

  // Next-state and next-output logic of the packet parser.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    len_h_d     = len_h_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    addr_d      = addr_q;
    bad_d       = bad_q;
    wr_ptr_d    = wr_ptr_q;
    tmo_d       = tmo_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    show_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;

    if (state_q == S_IDLE) begin
      tmo_d = '0;
      // Frame-errored bytes in IDLE are dropped silently, even if they look like SYNC.
      if (bus.rx_valid && !bus.rx_frame_err && (bus.rx_data == SYNC)) begin
        state_d = S_CMD;
        sum_d   = 8'h00;
      end else begin
        state_d = S_IDLE;
      end
    end else if (bus.rx_valid && bus.rx_frame_err) begin
      state_d    = S_IDLE;
      tmo_d      = '0;
      err_d      = 1'b1;
      err_code_d = 2'd2;
    end else if (bus.rx_valid) begin
      // A byte always wins over a coincident timeout expiry.
      tmo_d = '0;
      sum_d = sum_q + bus.rx_data;
      case (state_q)
        S_CMD: begin
          cmd_d   = bus.rx_data;
          state_d = S_LEN_H;
        end
        S_LEN_H: begin
          len_h_d = bus.rx_data;
          state_d = S_LEN_L;
        end
        S_LEN_L: begin
          cnt_d   = len_s;
          bad_d   = cmd_bad(cmd_q, len_s);
          state_d = (len_s == 16'd0) ? S_CSUM : S_PAYLOAD;
        end
        S_PAYLOAD: begin
          cnt_d  = cnt_q - 16'd1;
          addr_d = {addr_q[7:0], bus.rx_data};
          if ((cmd_q == CMD_WRITE) && !bad_q) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_ptr_q;
            mem_wdata_d = bus.rx_data;
            wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
          end else begin
            mem_we_d = 1'b0;
          end
          state_d = (cnt_q == 16'd1) ? S_CSUM : S_PAYLOAD;
        end
        S_CSUM: begin
          state_d = S_IDLE;
          sum_d   = sum_q;
          if (bad_q) begin
            err_d      = 1'b1;
            err_code_d = 2'd0;
          end else if (bus.rx_data != sum_q) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end else begin
            done_d = 1'b1;
            if (cmd_q == CMD_SET_ADDR) begin
              wr_ptr_d = ADDR_W'(addr_q);
            end else begin
              wr_ptr_d = wr_ptr_q;
            end
            show_d = (cmd_q == CMD_SHOW);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
      state_d    = S_IDLE;
      tmo_d      = '0;
      err_d      = 1'b1;
      err_code_d = 2'd3;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= 8'h00;
      len_h_q     <= 8'h00;
      cnt_q       <= 16'h0000;
      sum_q       <= 8'h00;
      addr_q      <= 16'h0000;
      bad_q       <= 1'b0;
      wr_ptr_q    <= '0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      show_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_h_q     <= len_h_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      addr_q      <= addr_d;
      bad_q       <= bad_d;
      wr_ptr_q    <= wr_ptr_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      show_q      <= show_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.show_pulse = show_q;
  assign bus.pkt_done   = done_q;
  assign bus.pkt_err    = err_q;
  assign bus.err_code   = err_code_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Directed self-checking bench for uart_pkt_ctrl: packets from the test
// plan are driven byte by byte; a negedge monitor records writes and pulses.
module tb_uart_pkt_ctrl;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 40;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  uart_pkt_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  uart_pkt_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .SYNC(8'hA5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  int         done_n = 0, err_n = 0, show_n = 0;
  logic [1:0] last_code = 2'd0;
  logic [15:0] we_addr[$];
  logic [7:0]  we_data[$];

  int d0, e0, s0, w0;
  logic [7:0] pk[$];

  // Record every write strobe and completion pulse, one sample per cycle.
  always @(negedge clock) begin
    if (bus.mem_we) begin
      we_addr.push_back(bus.mem_addr);
      we_data.push_back(bus.mem_wdata);
    end
    if (bus.pkt_done)   done_n <= done_n + 1;
    if (bus.show_pulse) show_n <= show_n + 1;
    if (bus.pkt_err) begin
      err_n     <= err_n + 1;
      last_code <= bus.err_code;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic fe);
    @(negedge clock);
    bus.rx_data      = b;
    bus.rx_valid     = 1'b1;
    bus.rx_frame_err = fe;
    @(negedge clock);
    bus.rx_valid     = 1'b0;
    bus.rx_frame_err = 1'b0;
    repeat (14) @(negedge clock);
    #2;
  endtask

  task automatic send_pkt();
    foreach (pk[i]) send(pk[i], 1'b0);
  endtask

  task automatic mark();
    d0 = done_n; e0 = err_n; s0 = show_n; w0 = we_addr.size();
  endtask

  task automatic chk_pulses(input string tag, input int dn, input int en, input int sn);
    chk({tag, "_done"}, 32'(done_n - d0), 32'(dn));
    chk({tag, "_err"},  32'(err_n - e0),  32'(en));
    chk({tag, "_show"}, 32'(show_n - s0), 32'(sn));
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [15:0] a, input logic [7:0] d);
    logic [15:0] oa;
    logic [7:0]  od;
    oa = (w0 + idx < we_addr.size()) ? we_addr[w0 + idx] : 16'hxxxx;
    od = (w0 + idx < we_data.size()) ? we_data[w0 + idx] : 8'hxx;
    chk({tag, "_addr"}, 32'(oa), 32'(a));
    chk({tag, "_data"}, 32'(od), 32'(d));
  endtask

  initial begin
    bus.rx_data      = 8'h00;
    bus.rx_valid     = 1'b0;
    bus.rx_frame_err = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_mem_we",   32'(bus.mem_we),     32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr),   32'd0);
    chk("rst_wdata",    32'(bus.mem_wdata),  32'd0);
    chk("rst_pulses",   32'({bus.show_pulse, bus.pkt_done, bus.pkt_err}), 32'd0);
    chk("rst_err_code", 32'(bus.err_code),   32'd0);
    chk("rst_busy",     32'(bus.busy),       32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #2;

    // SET_ADDR 0x0100
    mark();
    pk = '{8'hA5, 8'h02, 8'h00, 8'h02, 8'h01, 8'h00, 8'h05};
    send_pkt();
    chk_pulses("setaddr", 1, 0, 0);
    chk("setaddr_nowrite", 32'(we_addr.size() - w0), 32'd0);

    // WRITE three bytes at 0x0100..0x0102
    mark();
    pk = '{8'hA5, 8'h01, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    send_pkt();
    chk("write_count", 32'(we_addr.size() - w0), 32'd3);
    chk_wr("write0", 0, 16'h0100, 8'h11);
    chk_wr("write1", 1, 16'h0101, 8'h22);
    chk_wr("write2", 2, 16'h0102, 8'h33);
    chk_pulses("write", 1, 0, 0);
    chk("idle_hold_addr", 32'(bus.mem_addr), 32'h0102);

    // SHOW good, with busy observed mid-packet
    mark();
    send(8'hA5, 1'b0);
    chk("busy_after_sync", 32'(bus.busy), 32'd1);
    pk = '{8'h03, 8'h00, 8'h00, 8'h03};
    send_pkt();
    chk_pulses("show_ok", 1, 0, 1);
    chk("busy_after_done", 32'(bus.busy), 32'd0);

    // SHOW with bad checksum
    mark();
    pk = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h04};
    send_pkt();
    chk_pulses("show_bad", 0, 1, 0);
    chk("show_bad_code", 32'(last_code), 32'd1);

    // Timeout exactly TIMEOUT silent cycles after the last byte
    mark();
    send(8'hA5, 1'b0);
    @(negedge clock);
    bus.rx_data  = 8'h01;
    bus.rx_valid = 1'b1;
    @(negedge clock);
    bus.rx_valid = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clock);
    #1;
    chk("tmo_early_err",  32'(bus.pkt_err), 32'd0);
    chk("tmo_early_busy", 32'(bus.busy),    32'd1);
    @(negedge clock);
    #1;
    chk("tmo_err",      32'(bus.pkt_err),  32'd1);
    chk("tmo_code",     32'(bus.err_code), 32'd3);
    chk("tmo_busy",     32'(bus.busy),     32'd0);
    repeat (14) @(negedge clock);
    #2;
    chk_pulses("tmo", 0, 1, 0);
    mark();
    pk = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h03};
    send_pkt();
    chk_pulses("show_after_tmo", 1, 0, 1);

    // Frame error mid-payload: one write committed, then abort
    mark();
    pk = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'h11};
    send_pkt();
    send(8'h22, 1'b1);
    chk("ferr_count", 32'(we_addr.size() - w0), 32'd1);
    chk_wr("ferr_w0", 0, 16'h0103, 8'h11);
    chk_pulses("ferr", 0, 1, 0);
    chk("ferr_code", 32'(last_code), 32'd2);

    // Pointer wrap at the top of the buffer
    mark();
    pk = '{8'hA5, 8'h02, 8'h00, 8'h02, 8'hFF, 8'hFF, 8'h02};
    send_pkt();
    pk = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h68};
    send_pkt();
    chk("wrap_count", 32'(we_addr.size() - w0), 32'd2);
    chk_wr("wrap0", 0, 16'hFFFF, 8'hAA);
    chk_wr("wrap1", 1, 16'h0000, 8'hBB);
    chk_pulses("wrap", 2, 0, 0);

    // SET_ADDR with wrong length: code 0, pointer kept at 0x0001
    mark();
    pk = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h07, 8'h0A};
    send_pkt();
    chk_pulses("badlen", 0, 1, 0);
    chk("badlen_code", 32'(last_code), 32'd0);
    pk = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h5C, 8'h5E};
    send_pkt();
    chk_wr("badlen_ptr", 0, 16'h0001, 8'h5C);

    // Reset mid-packet: no pulse, pointer back to zero
    mark();
    send(8'hA5, 1'b0);
    send(8'h01, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    #2;
    chk_pulses("midrst", 0, 0, 0);
    mark();
    pk = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h77, 8'h79};
    send_pkt();
    chk_wr("rst_ptr", 0, 16'h0000, 8'h77);
    chk_pulses("rst_ptr", 1, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
